run_watchdog: RTL and testbench

Synthesizable run controller for the CPU simulation top. It sequences the core reset after the global reset and watches `CHANNELS` monitor channels for halt, commit progress and errors. It raises a sticky pass/fail verdict with a cause code, so the bench only waits on `finished`. It replaces ad-hoc timeout and halt loops in the top-level bench, and adds a per-run timeout, a no-commit (deadlock) watchdog and a configurable error drain.

---
 rtl/run_watchdog_pkg.sv | 31 +++
 rtl/lowest_set_idx.sv | 24 ++
 rtl/run_watchdog.sv | 166 ++++++++++++++++
 tb/tb_run_watchdog.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/run_watchdog_pkg.sv
// Shared types and defaults for the simulation run watchdog.
// States, verdict cause codes and counter width helper.
package run_watchdog_pkg;

    localparam int CHANNELS_DEF     = 8;
    localparam int RESET_CYCLES_DEF = 2;
    localparam int ERROR_DRAIN_DEF  = 5;
    localparam int CNT_W_DEF        = 32;

    typedef enum logic [2:0] {
        ST_RESET = 3'd0,
        ST_RUN   = 3'd1,
        ST_DRAIN = 3'd2,
        ST_PASS  = 3'd3,
        ST_FAIL  = 3'd4
    } state_e;

    typedef enum logic [2:0] {
        CAUSE_NONE    = 3'd0,
        CAUSE_TIMEOUT = 3'd1,
        CAUSE_MON_ERR = 3'd2,
        CAUSE_MEM_ERR = 3'd3,
        CAUSE_STALL   = 3'd4
    } cause_e;

    // Bits needed to count 0..v, never less than one.
    function automatic int cnt_width(input int v);
        return (v < 1) ? 1 : $clog2(v + 1);
    endfunction

endpackage

// File: rtl/lowest_set_idx.sv
// Priority encoder: index of the lowest set bit.
// valid doubles as a cheap any-bit-set flag.
module lowest_set_idx #(
    parameter int W  = 8,
    parameter int IW = $clog2(W)
) (
    input  logic [W-1:0]  bits,
    output logic [IW-1:0] idx,
    output logic          valid
);

    // Scan from the top so the lowest set bit is the last to win.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int i = W - 1; i >= 0; i--) begin
            if (bits[i]) begin
                idx   = IW'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/run_watchdog.sv
// Run controller: core reset sequencing, halt/commit/error
// watch, and a sticky pass/fail verdict with cause code.
module run_watchdog
    import run_watchdog_pkg::*;
#(
    parameter int CHANNELS     = CHANNELS_DEF,
    parameter int RESET_CYCLES = RESET_CYCLES_DEF,
    parameter int ERROR_DRAIN  = ERROR_DRAIN_DEF,
    parameter int CNT_W        = CNT_W_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [CNT_W-1:0]            timeout_cycles,
    input  logic [CNT_W-1:0]            stall_limit,
    input  logic [CHANNELS-1:0]         halt,
    input  logic [CHANNELS-1:0]         commit,
    input  logic                        mon_error,
    input  logic                        mem_error,
    output logic                        core_rst,
    output logic                        running,
    output logic                        finished,
    output logic                        failed,
    output cause_e                      fail_cause,
    output logic [$clog2(CHANNELS)-1:0] halt_ch,
    output logic [63:0]                 cycle_count,
    output logic [63:0]                 commit_count
);

    localparam int IW  = $clog2(CHANNELS);
    localparam int PW  = $clog2(CHANNELS + 1);
    localparam int RCW = cnt_width(RESET_CYCLES);
    localparam int DCW = cnt_width(ERROR_DRAIN);
    localparam int DRAIN_LAST = (ERROR_DRAIN > 0) ? ERROR_DRAIN - 1 : 0;

    state_e             state, state_n;
    cause_e             cause_n;
    logic [IW-1:0]      halt_ch_n, halt_idx;
    logic               any_halt, any_commit;
    logic [PW-1:0]      pop;
    logic [RCW-1:0]     rst_cnt, rst_cnt_n;
    logic [DCW-1:0]     drain_cnt, drain_cnt_n;
    logic [CNT_W-1:0]   tmo_cnt, tmo_cnt_n;
    logic [CNT_W-1:0]   stall_cnt, stall_cnt_n;
    logic [CNT_W-1:0]   stall_lim, stall_lim_n;
    logic [63:0]        cyc_n, cmt_n;
    logic [64:0]        cmt_sum;

    lowest_set_idx #(.W(CHANNELS), .IW(IW)) u_halt_idx (
        .bits  (halt),
        .idx   (halt_idx),
        .valid (any_halt)
    );

    // Commits this cycle; nonzero means forward progress.
    always_comb begin
        pop = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            pop = pop + PW'(commit[i]);
        end
        any_commit = (pop != '0);
    end

    // Next-state, counter and verdict logic.
    always_comb begin
        state_n     = state;
        cause_n     = fail_cause;
        halt_ch_n   = halt_ch;
        rst_cnt_n   = rst_cnt;
        drain_cnt_n = drain_cnt;
        tmo_cnt_n   = tmo_cnt;
        stall_cnt_n = stall_cnt;
        stall_lim_n = stall_lim;
        cyc_n       = cycle_count;
        cmt_n       = commit_count;
        cmt_sum     = {1'b0, commit_count} + 65'(pop);
        unique case (state)
            ST_RESET: begin
                if (rst_cnt == RCW'(RESET_CYCLES - 1)) begin
                    state_n     = ST_RUN;
                    tmo_cnt_n   = timeout_cycles;
                    stall_cnt_n = stall_limit;
                    stall_lim_n = stall_limit;
                end else begin
                    rst_cnt_n = rst_cnt + RCW'(1);
                end
            end
            ST_RUN: begin
                cyc_n = (cycle_count == '1) ? cycle_count
                                            : cycle_count + 64'd1;
                cmt_n = cmt_sum[64] ? '1 : cmt_sum[63:0];
                tmo_cnt_n = (tmo_cnt != '0) ? tmo_cnt - CNT_W'(1) : '0;
                if (any_commit) begin
                    stall_cnt_n = stall_lim;
                end else begin
                    stall_cnt_n = (stall_cnt != '0)
                                ? stall_cnt - CNT_W'(1) : '0;
                end
                if (mon_error || mem_error) begin
                    cause_n     = mon_error ? CAUSE_MON_ERR
                                            : CAUSE_MEM_ERR;
                    drain_cnt_n = '0;
                    state_n     = (ERROR_DRAIN == 0) ? ST_FAIL
                                                     : ST_DRAIN;
                end else if (any_halt) begin
                    halt_ch_n = halt_idx;
                    state_n   = ST_PASS;
                end else if (tmo_cnt == CNT_W'(1)) begin
                    cause_n = CAUSE_TIMEOUT;
                    state_n = ST_FAIL;
                end else if (stall_cnt == CNT_W'(1) && !any_commit) begin
                    cause_n = CAUSE_STALL;
                    state_n = ST_FAIL;
                end
            end
            ST_DRAIN: begin
                if (drain_cnt == DCW'(DRAIN_LAST)) begin
                    state_n = ST_FAIL;
                end else begin
                    drain_cnt_n = drain_cnt + DCW'(1);
                end
            end
            ST_PASS, ST_FAIL: begin
                state_n = state;
            end
            default: begin
                state_n = ST_RESET;
            end
        endcase
    end

    // State register; every output is a flop fed from next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_RESET;
            core_rst     <= 1'b1;
            running      <= 1'b0;
            finished     <= 1'b0;
            failed       <= 1'b0;
            fail_cause   <= CAUSE_NONE;
            halt_ch      <= '0;
            rst_cnt      <= '0;
            drain_cnt    <= '0;
            tmo_cnt      <= '0;
            stall_cnt    <= '0;
            stall_lim    <= '0;
            cycle_count  <= '0;
            commit_count <= '0;
        end else begin
            state        <= state_n;
            core_rst     <= (state_n == ST_RESET);
            running      <= (state_n == ST_RUN);
            finished     <= (state_n == ST_PASS) || (state_n == ST_FAIL);
            failed       <= (state_n == ST_FAIL);
            fail_cause   <= cause_n;
            halt_ch      <= halt_ch_n;
            rst_cnt      <= rst_cnt_n;
            drain_cnt    <= drain_cnt_n;
            tmo_cnt      <= tmo_cnt_n;
            stall_cnt    <= stall_cnt_n;
            stall_lim    <= stall_lim_n;
            cycle_count  <= cyc_n;
            commit_count <= cmt_n;
        end
    end

endmodule

// File: tb/tb_run_watchdog.sv
// Directed bench for run_watchdog: reset sequencing, halt,
// timeout, stall, error drain and reset during drain.
module tb_run_watchdog;
    import run_watchdog_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] timeout_cycles;
    logic [31:0] stall_limit;
    logic [7:0]  halt;
    logic [7:0]  commit;
    logic        mon_error;
    logic        mem_error;
    logic        core_rst;
    logic        running;
    logic        finished;
    logic        failed;
    cause_e      fail_cause;
    logic [2:0]  halt_ch;
    logic [63:0] cycle_count;
    logic [63:0] commit_count;

    int n_pass  = 0;
    int n_total = 0;

    run_watchdog #(
        .CHANNELS(8), .RESET_CYCLES(2), .ERROR_DRAIN(5), .CNT_W(32)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .timeout_cycles (timeout_cycles),
        .stall_limit    (stall_limit),
        .halt           (halt),
        .commit         (commit),
        .mon_error      (mon_error),
        .mem_error      (mem_error),
        .core_rst       (core_rst),
        .running        (running),
        .finished       (finished),
        .failed         (failed),
        .fail_cause     (fail_cause),
        .halt_ch        (halt_ch),
        .cycle_count    (cycle_count),
        .commit_count   (commit_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout bench did not finish");
        $fatal(1, "bench hung");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        halt      = '0;
        commit    = '0;
        mon_error = 1'b0;
        mem_error = 1'b0;
    endtask

    // Reset 3 cycles, release, and wait the 2 reset-sequencing edges.
    task automatic start_run(input logic [31:0] tmo,
                             input logic [31:0] stl);
        clear_inputs();
        timeout_cycles = tmo;
        stall_limit    = stl;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        repeat (2) tick();
        n_total++;
        if (running !== 1'b1)
            $display("FAIL start_running got=%0b exp=1", running);
        else n_pass++;
    endtask

    task automatic test_reset();
        clear_inputs();
        timeout_cycles = '0;
        stall_limit    = '0;
        rst = 1'b1;
        repeat (3) tick();
        n_total++;
        if ({core_rst, running, finished, failed} !== 4'b1000)
            $display("FAIL reset_flags got=%b exp=1000",
                     {core_rst, running, finished, failed});
        else n_pass++;
        n_total++;
        if (fail_cause !== CAUSE_NONE || halt_ch !== 3'd0)
            $display("FAIL reset_cause got=%0d/%0d exp=0/0",
                     fail_cause, halt_ch);
        else n_pass++;
        n_total++;
        if (cycle_count !== 64'd0 || commit_count !== 64'd0)
            $display("FAIL reset_counts got=%0d/%0d exp=0/0",
                     cycle_count, commit_count);
        else n_pass++;
        rst = 1'b0;
        tick();
        n_total++;
        if (core_rst !== 1'b1 || running !== 1'b0)
            $display("FAIL reset_e0 got=%b%b exp=10", core_rst, running);
        else n_pass++;
        tick();
        n_total++;
        if (core_rst !== 1'b0 || running !== 1'b1)
            $display("FAIL reset_e1 got=%b%b exp=01", core_rst, running);
        else n_pass++;
        n_total++;
        if (cycle_count !== 64'd0)
            $display("FAIL reset_run_cc got=%0d exp=0", cycle_count);
        else n_pass++;
    endtask

    task automatic test_halt();
        start_run(32'd0, 32'd0);
        commit = 8'b0000_0011;
        repeat (9) tick();
        n_total++;
        if (finished !== 1'b0)
            $display("FAIL halt_early got=%0b exp=0", finished);
        else n_pass++;
        halt = 8'b0010_0100;
        tick();
        halt   = '0;
        commit = '0;
        n_total++;
        if ({finished, failed, running} !== 3'b100)
            $display("FAIL halt_flags got=%b exp=100",
                     {finished, failed, running});
        else n_pass++;
        n_total++;
        if (halt_ch !== 3'd2)
            $display("FAIL halt_ch got=%0d exp=2", halt_ch);
        else n_pass++;
        n_total++;
        if (cycle_count !== 64'd10 || commit_count !== 64'd20)
            $display("FAIL halt_counts got=%0d/%0d exp=10/20",
                     cycle_count, commit_count);
        else n_pass++;
        commit = 8'hff;
        repeat (3) tick();
        n_total++;
        if (finished !== 1'b1 || cycle_count !== 64'd10
            || commit_count !== 64'd20)
            $display("FAIL halt_sticky got=%0b/%0d/%0d exp=1/10/20",
                     finished, cycle_count, commit_count);
        else n_pass++;
    endtask

    task automatic test_timeout();
        start_run(32'd100, 32'd0);
        for (int k = 1; k <= 100; k++) begin
            commit = (k % 2 == 1) ? 8'h01 : 8'h00;
            if (k == 2) timeout_cycles = 32'd5;
            tick();
            if (k == 99) begin
                n_total++;
                if (finished !== 1'b0)
                    $display("FAIL tmo_early got=%0b exp=0", finished);
                else n_pass++;
            end
        end
        commit = '0;
        n_total++;
        if ({finished, failed} !== 2'b11 || fail_cause !== CAUSE_TIMEOUT)
            $display("FAIL tmo_verdict got=%b/%0d exp=11/1",
                     {finished, failed}, fail_cause);
        else n_pass++;
        n_total++;
        if (cycle_count !== 64'd100 || commit_count !== 64'd50)
            $display("FAIL tmo_counts got=%0d/%0d exp=100/50",
                     cycle_count, commit_count);
        else n_pass++;
    endtask

    task automatic test_stall();
        start_run(32'd0, 32'd16);
        for (int k = 1; k <= 66; k++) begin
            commit = (k <= 50) ? 8'h81 : 8'h00;
            if (k == 3) stall_limit = 32'd3;
            tick();
            if (k == 65) begin
                n_total++;
                if (finished !== 1'b0)
                    $display("FAIL stall_early got=%0b exp=0", finished);
                else n_pass++;
            end
        end
        n_total++;
        if ({finished, failed} !== 2'b11 || fail_cause !== CAUSE_STALL)
            $display("FAIL stall_verdict got=%b/%0d exp=11/4",
                     {finished, failed}, fail_cause);
        else n_pass++;
        n_total++;
        if (cycle_count !== 64'd66 || commit_count !== 64'd100)
            $display("FAIL stall_counts got=%0d/%0d exp=66/100",
                     cycle_count, commit_count);
        else n_pass++;
    endtask

    task automatic test_error_drain();
        start_run(32'd0, 32'd0);
        repeat (3) tick();
        mem_error = 1'b1;
        halt      = 8'h01;
        tick();
        n_total++;
        if ({running, finished} !== 2'b00)
            $display("FAIL drain_enter got=%b exp=00", {running, finished});
        else n_pass++;
        mem_error = 1'b0;
        mon_error = 1'b1;
        halt      = 8'hff;
        repeat (4) tick();
        n_total++;
        if (finished !== 1'b0)
            $display("FAIL drain_early got=%0b exp=0", finished);
        else n_pass++;
        tick();
        clear_inputs();
        n_total++;
        if ({finished, failed} !== 2'b11 || fail_cause !== CAUSE_MEM_ERR)
            $display("FAIL drain_mem got=%b/%0d exp=11/3",
                     {finished, failed}, fail_cause);
        else n_pass++;
        n_total++;
        if (cycle_count !== 64'd4 || halt_ch !== 3'd0)
            $display("FAIL drain_cc got=%0d/%0d exp=4/0",
                     cycle_count, halt_ch);
        else n_pass++;
        start_run(32'd0, 32'd0);
        mon_error = 1'b1;
        mem_error = 1'b1;
        tick();
        clear_inputs();
        repeat (5) tick();
        n_total++;
        if ({finished, failed} !== 2'b11 || fail_cause !== CAUSE_MON_ERR)
            $display("FAIL drain_mon got=%b/%0d exp=11/2",
                     {finished, failed}, fail_cause);
        else n_pass++;
    endtask

    task automatic test_reset_mid_drain();
        start_run(32'd0, 32'd0);
        commit = 8'h0f;
        tick();
        commit    = '0;
        mem_error = 1'b1;
        tick();
        mem_error = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        n_total++;
        if ({core_rst, running, finished, failed} !== 4'b1000)
            $display("FAIL rst_drain_flags got=%b exp=1000",
                     {core_rst, running, finished, failed});
        else n_pass++;
        n_total++;
        if (fail_cause !== CAUSE_NONE || cycle_count !== 64'd0
            || commit_count !== 64'd0)
            $display("FAIL rst_drain_clear got=%0d/%0d/%0d exp=0/0/0",
                     fail_cause, cycle_count, commit_count);
        else n_pass++;
        start_run(32'd0, 32'd0);
        repeat (2) tick();
        halt = 8'h80;
        tick();
        halt = '0;
        n_total++;
        if ({finished, failed} !== 2'b10 || halt_ch !== 3'd7)
            $display("FAIL rerun_pass got=%b/%0d exp=10/7",
                     {finished, failed}, halt_ch);
        else n_pass++;
        n_total++;
        if (cycle_count !== 64'd3)
            $display("FAIL rerun_cc got=%0d exp=3", cycle_count);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_halt();
        test_timeout();
        test_stall();
        test_error_drain();
        test_reset_mid_drain();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
